// File: rtl/countdown_pkg.sv
// Shared types and helpers for the countdown arbiter.
//   state_t  : arbiter FSM states
//   pick_t   : result of a round-robin search (valid + winner index)
//   rr_pick  : first set request at or after ptr, wrapping modulo n
package countdown_pkg;

  localparam int DEF_N = 4;
  localparam int DEF_W = 4;
  localparam int MAX_N = 8;
  localparam int IDX_W = 3;

  typedef enum logic [1:0] {IDLE, COUNT, DONE} state_t;

  typedef struct packed {
    logic             valid;
    logic [IDX_W-1:0] idx;
  } pick_t;

  // req is padded to MAX_N; only the low n bits take part in the search.
  function automatic pick_t rr_pick(input logic [MAX_N-1:0] req,
                                    input logic [IDX_W-1:0] ptr,
                                    input int               n);
    pick_t r;
    int    k;
    r = '0;
    for (int i = 0; i < MAX_N; i++) begin
      k = int'(ptr) + i;
      if (k >= n) k = k - n;
      if (i < n && !r.valid && req[k[IDX_W-1:0]]) begin
        r.valid = 1'b1;
        r.idx   = k[IDX_W-1:0];
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/countdown_arbiter_if.sv
// Request/response bundle between the requesters and the arbiter.
//   req      : per-requester request level
//   load_val : per-requester countdown length, requester k owns [k*W +: W]
//   grant    : one-hot owner of the counter
//   done     : one-cycle completion pulse to the owner
//   busy     : counter owned
//   count    : current counter value
interface countdown_arbiter_if #(
  parameter int N = 4,
  parameter int W = 4
);
  logic [N-1:0]   req;
  logic [N*W-1:0] load_val;
  logic [N-1:0]   grant;
  logic [N-1:0]   done;
  logic           busy;
  logic [W-1:0]   count;

  modport master (output req, load_val, input grant, done, busy, count);
  modport slave  (input req, load_val, output grant, done, busy, count);
endinterface

// File: rtl/countdown_core.sv
// Loadable W-bit down counter that stops at zero.
//   clk, rst : clock, async active-high reset
//   load     : load load_val (wins over en)
//   en       : decrement by one unless already zero
//   count    : current value
//   zero     : count == 0
module countdown_core #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic [W-1:0] count,
  output logic         zero
);

  logic [W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load)                        count_d = load_val;
    else if (en && count_q != '0)    count_d = count_q - 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) count_q <= '0;
    else     count_q <= count_d;
  end

  assign count = count_q;
  assign zero  = (count_q == '0);

endmodule

// File: rtl/countdown_arbiter.sv
// Round-robin sharing of one down counter between N requesters.
//   clk, rst : clock, async active-high reset
//   bus      : slave side of countdown_arbiter_if (req/load_val in,
//              grant/done/busy/count out)
// The winner's load_val is captured only on the granting edge. Dropping
// req of the owner while counting aborts without a done pulse.
module countdown_arbiter
  import countdown_pkg::*;
#(
  parameter int N = DEF_N,
  parameter int W = DEF_W
) (
  input  logic               clk,
  input  logic               rst,
  countdown_arbiter_if.slave bus
);

  state_t           state_q, state_d;
  logic [N-1:0]     grant_q, grant_d;
  logic [N-1:0]     done_q,  done_d;
  logic [IDX_W-1:0] ptr_q,   ptr_d;
  logic [IDX_W-1:0] win_q,   win_d;

  logic [MAX_N-1:0] req_pad;
  pick_t            pk;
  logic [W-1:0]     ld_sel;
  logic             ld, en, zero;
  logic [W-1:0]     cnt;

  function automatic logic [IDX_W-1:0] nxt(input logic [IDX_W-1:0] w);
    return (w == IDX_W'(N-1)) ? IDX_W'(0) : w + 1'b1;
  endfunction

  always_comb begin
    req_pad        = '0;
    req_pad[N-1:0] = bus.req;
  end

  assign pk = rr_pick(req_pad, ptr_q, N);

  always_comb begin
    ld_sel = '0;
    for (int k = 0; k < N; k++)
      if (pk.idx == IDX_W'(k)) ld_sel = bus.load_val[k*W +: W];
  end

  // Counter only moves while the owner still requests; an abort freezes it.
  assign ld = (state_q == IDLE) && pk.valid;
  assign en = (state_q == COUNT) && req_pad[win_q];

  countdown_core #(.W(W)) u_core (
    .clk      (clk),
    .rst      (rst),
    .load     (ld),
    .load_val (ld_sel),
    .en       (en),
    .count    (cnt),
    .zero     (zero)
  );

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    done_d  = '0;
    ptr_d   = ptr_q;
    win_d   = win_q;
    unique case (state_q)
      IDLE: begin
        if (pk.valid) begin
          state_d = COUNT;
          win_d   = pk.idx;
          for (int k = 0; k < N; k++) grant_d[k] = (pk.idx == IDX_W'(k));
        end
      end
      COUNT: begin
        // abort outranks reaching zero
        if (!req_pad[win_q]) begin
          state_d = IDLE;
          grant_d = '0;
          ptr_d   = nxt(win_q);
        end else if (zero) begin
          state_d = DONE;
          done_d  = grant_q;
        end
      end
      DONE: begin
        state_d = IDLE;
        grant_d = '0;
        ptr_d   = nxt(win_q);
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      grant_q <= '0;
      done_q  <= '0;
      ptr_q   <= '0;
      win_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      done_q  <= done_d;
      ptr_q   <= ptr_d;
      win_q   <= win_d;
    end
  end

  assign bus.grant = grant_q;
  assign bus.done  = done_q;
  assign bus.busy  = |grant_q;
  assign bus.count = cnt;

endmodule
